sram_ctrl: RTL and testbench

Bus-side controller for the external 512K×8 asynchronous SRAM (IS61WV5128BLL).
- Accepts byte or 16-bit word requests from the CPU/system bus over a req/ack handshake.
- Splits word accesses into two byte cycles and generates glitch-free registered CEN/OEN/WEN/AD strobes with programmable wait states.
- Owns the tri-state SRAM data bus and sits between the memory interconnect and the SRAM pins.

---
 rtl/sram_ctrl.sv | 128 ++++++++++++
 tb/tb_sram_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Bus-side controller for a 512Kx8 asynchronous SRAM: byte/word requests over req/ack,
// split into byte cycles with registered CEN/OEN/WEN/AD strobes and programmable wait states.
module sram_ctrl #(
    parameter int unsigned WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic        word,
    input  logic [18:0] adr,
    input  logic [15:0] wdat,
    output logic [15:0] rdat,
    output logic        ack,
    output logic        busy,
    output logic        sram_cen,
    output logic        sram_oen,
    output logic        sram_wen,
    output logic [18:0] sram_ad,
    inout  wire  [7:0]  sram_dq
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] ACC   = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    logic [2:0]  state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        op_we, op_word, hi;
    logic [18:1] op_adr;
    logic [7:0]  op_wdat_hi;
    logic [7:0]  dq_out;
    logic        dq_oe;
    logic [7:0]  rd_lo;
    logic        last, accept, to_high, nxt_we, nxt_strobe;

    assign sram_dq = dq_oe ? dq_out : 8'bz;

    assign last   = (state == ACC) && (cnt == WAIT_CNT);
    assign accept = (state == IDLE) && req;

    always_comb begin
        state_d = state;
        cnt_d   = 4'd0;
        unique case (state)
            IDLE:  if (req) state_d = SETUP;
            SETUP: state_d = ACC;
            ACC: begin
                if (!last) begin
                    cnt_d = cnt + 4'd1;
                end else if (op_we) begin
                    state_d = HOLD;
                end else if (op_word && !hi) begin
                    state_d = SETUP;
                end else begin
                    state_d = DONE;
                end
            end
            HOLD:  state_d = (op_word && !hi) ? SETUP : DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Entering SETUP from anywhere but IDLE means the high byte of a word is next.
    assign to_high    = (state_d == SETUP) && (state != IDLE);
    assign nxt_we     = (state == IDLE) ? we : op_we;
    assign nxt_strobe = (state_d == SETUP) || (state_d == ACC) || (state_d == HOLD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            op_we      <= 1'b0;
            op_word    <= 1'b0;
            hi         <= 1'b0;
            op_adr     <= '0;
            op_wdat_hi <= 8'h00;
            dq_out     <= 8'h00;
            dq_oe      <= 1'b0;
            rd_lo      <= 8'h00;
            rdat       <= 16'h0000;
            ack        <= 1'b0;
            busy       <= 1'b0;
            sram_cen   <= 1'b1;
            sram_oen   <= 1'b1;
            sram_wen   <= 1'b1;
            sram_ad    <= 19'h0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            sram_cen <= !nxt_strobe;
            sram_oen <= !(!nxt_we && ((state_d == SETUP) || (state_d == ACC)));
            sram_wen <= !(nxt_we && (state_d == ACC));
            dq_oe    <= nxt_we && nxt_strobe;
            ack      <= (state_d == DONE);
            busy     <= (state_d != IDLE);

            if (accept) begin
                op_we      <= we;
                op_word    <= word;
                op_adr     <= adr[18:1];
                op_wdat_hi <= wdat[15:8];
                hi         <= 1'b0;
                sram_ad    <= {adr[18:1], adr[0] & ~word};
                dq_out     <= wdat[7:0];
            end else if (to_high) begin
                hi      <= 1'b1;
                sram_ad <= {op_adr, 1'b1};
                dq_out  <= op_wdat_hi;
            end

            // Sample the SRAM byte on the edge that ends the last ACC cycle of a read.
            if (last && !op_we) begin
                if (op_word && !hi) begin
                    rd_lo <= sram_dq;
                end else begin
                    rdat <= op_word ? {sram_dq, rd_lo} : {8'h00, sram_dq};
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: WAIT=1 instance with an SRAM model, plus WAIT=0 and
// WAIT=3 instances for back-to-back timing and bus turnaround.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, req, we, word;
    logic [18:0] adr;
    logic [15:0] wdat;

    logic [15:0] rdat0, rdat1, rdat3;
    logic        ack0, ack1, ack3, busy0, busy1, busy3;
    logic        cen0, cen1, cen3, oen0, oen1, oen3, wen0, wen1, wen3;
    logic [18:0] ad0, ad1, ad3;
    wire  [7:0]  dq0, dq1, dq3;

    int checks = 0;
    int failures = 0;
    int conflicts0 = 0, conflicts1 = 0, conflicts3 = 0;

    logic [7:0] mem [0:524287];

    always #5 clk = ~clk;

    sram_ctrl #(.WAIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .word(word), .adr(adr), .wdat(wdat),
        .rdat(rdat1), .ack(ack1), .busy(busy1), .sram_cen(cen1), .sram_oen(oen1),
        .sram_wen(wen1), .sram_ad(ad1), .sram_dq(dq1)
    );
    sram_ctrl #(.WAIT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .word(word), .adr(adr), .wdat(wdat),
        .rdat(rdat0), .ack(ack0), .busy(busy0), .sram_cen(cen0), .sram_oen(oen0),
        .sram_wen(wen0), .sram_ad(ad0), .sram_dq(dq0)
    );
    sram_ctrl #(.WAIT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .word(word), .adr(adr), .wdat(wdat),
        .rdat(rdat3), .ack(ack3), .busy(busy3), .sram_cen(cen3), .sram_oen(oen3),
        .sram_wen(wen3), .sram_ad(ad3), .sram_dq(dq3)
    );

    // SRAM models: full memory behind u1, constant read data behind the others.
    assign dq1 = (!cen1 && !oen1) ? mem[ad1] : 8'bz;
    assign dq0 = (!cen0 && !oen0) ? 8'h5A : 8'bz;
    assign dq3 = (!cen3 && !oen3) ? 8'h5A : 8'bz;

    always @(posedge clk) begin
        if (!cen1 && !wen1) mem[ad1] <= dq1;
    end

    // Bus monitor: output enable must never overlap the controller's own drive.
    always @(negedge clk) begin
        if (!oen0 && u0.dq_oe) conflicts0++;
        if (!oen1 && u1.dq_oe) conflicts1++;
        if (!oen3 && u3.dq_oe) conflicts3++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called just after a rising edge; that cycle is cycle 0. Returns ack cycle or -1.
    task automatic run_txn(input logic t_we, input logic t_word, input logic [18:0] t_adr,
                           input logic [15:0] t_wdat, output int lat);
        lat  = -1;
        we   = t_we;
        word = t_word;
        adr  = t_adr;
        wdat = t_wdat;
        req  = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack1 && lat < 0) lat = n;
            @(posedge clk);
            #1 req = 1'b0;
            if (lat >= 0) break;
        end
    endtask

    typedef struct {
        logic        we;
        logic        word;
        logic [18:0] adr;
        logic [15:0] wdat;
        int          lat;
        logic [15:0] rdat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        int a0_1, a0_2, a3_1, a3_2, ack_seen;
        logic [7:0] old201;

        for (int i = 0; i < 524288; i++) mem[i] = 8'h00;

        vecs[0] = '{1'b1, 1'b0, 19'h12345, 16'h00A5, 5, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 19'h12345, 16'h0000, 4, 16'h00A5};
        vecs[2] = '{1'b1, 1'b1, 19'h00100, 16'hBEEF, 9, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, 19'h00101, 16'h0000, 7, 16'hBEEF};
        vecs[4] = '{1'b1, 1'b1, 19'h7FFFF, 16'h1234, 9, 16'h0000};
        vecs[5] = '{1'b0, 1'b1, 19'h7FFFE, 16'h0000, 7, 16'h1234};
        vecs[6] = '{1'b0, 1'b0, 19'h7FFFF, 16'h0000, 4, 16'h0012};
        vecs[7] = '{1'b0, 1'b0, 19'h00100, 16'h0000, 4, 16'h00EF};

        // Reset held with req asserted: nothing may start.
        rst_n = 1'b0;
        req   = 1'b1;
        we    = 1'b1;
        word  = 1'b1;
        adr   = 19'h00055;
        wdat  = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("reset_state_%0d", i),
                  {11'h0, cen1, oen1, wen1, u1.dq_oe, ack1, busy1, rdat1},
                  {11'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        req = 1'b0;
        @(negedge clk);
        check("no_accept_after_reset", {30'h0, busy1, cen1}, {30'h0, 1'b0, 1'b1});
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].we, vecs[i].word, vecs[i].adr, vecs[i].wdat, lat);
            check($sformatf("vec%0d_ack_cycle", i), 32'(lat), 32'(vecs[i].lat));
            if (!vecs[i].we) check($sformatf("vec%0d_rdat", i), {16'h0, rdat1},
                                   {16'h0, vecs[i].rdat});
        end

        check("mem_12345", {24'h0, mem[19'h12345]}, 32'hA5);
        check("mem_00100", {24'h0, mem[19'h00100]}, 32'hEF);
        check("mem_00101", {24'h0, mem[19'h00101]}, 32'hBE);
        check("mem_7fffe", {24'h0, mem[19'h7FFFE]}, 32'h34);
        check("mem_7ffff", {24'h0, mem[19'h7FFFF]}, 32'h12);
        check("mem_00000_no_wrap", {24'h0, mem[19'h00000]}, 32'h00);

        // req held high: consecutive byte reads on the WAIT=0 and WAIT=3 instances.
        do_reset();
        @(posedge clk);
        #1;
        a0_1 = -1; a0_2 = -1; a3_1 = -1; a3_2 = -1;
        we = 1'b0; word = 1'b0; adr = 19'h00010; req = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (ack0) begin
                if (a0_1 < 0) a0_1 = n;
                else if (a0_2 < 0) a0_2 = n;
            end
            if (ack3) begin
                if (a3_1 < 0) a3_1 = n;
                else if (a3_2 < 0) a3_2 = n;
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        check("wait0_ack1", 32'(a0_1), 32'd3);
        check("wait0_ack2", 32'(a0_2), 32'd7);
        check("wait3_ack1", 32'(a3_1), 32'd6);
        check("wait3_ack2", 32'(a3_2), 32'd13);
        check("wait0_rdat", {16'h0, rdat0}, 32'h005A);

        // Reset during the high-byte ACC of a word write.
        do_reset();
        @(posedge clk);
        #1;
        old201 = mem[19'h00201];
        we = 1'b1; word = 1'b1; adr = 19'h00200; wdat = 16'hCAFE; req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1 req = 1'b0;
        end
        @(negedge clk);
        check("hi_acc_wen_low", {24'h0, ad1[7:0], 3'b0, wen1}, {24'h0, 8'h01, 4'b0000});
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_pins", {27'h0, wen1, cen1, u1.dq_oe, ack1, busy1},
              {27'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1 rst_n = 1'b1;
        ack_seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ack1) ack_seen++;
        end
        check("abort_no_ack", 32'(ack_seen), 32'd0);
        check("abort_mem_200", {24'h0, mem[19'h00200]}, 32'hFE);
        check("abort_mem_201_ok",
              {31'h0, (mem[19'h00201] === old201) || (mem[19'h00201] === 8'hCA)}, 32'd1);

        check("turnaround_wait0", 32'(conflicts0), 32'd0);
        check("turnaround_wait1", 32'(conflicts1), 32'd0);
        check("turnaround_wait3", 32'(conflicts3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
